lut_cfg_loader: RTL and testbench
=================================

// Module: lut_cfg_loader
// PURPOSE
//   Hardware programmer for the 4-input LUT fabric: receives a serial configuration bitstream
//   through a valid/ready handshake and produces the 16-bit lut_config words that drive lut4_1 instances.
//   It takes over the configuration writes that today only the bench performs.
//   All words are shadowed, then committed atomically, so LUTs never see a partial configuration.
// PARAMETERS
//   NUM_LUTS  4   number of LUT configuration words per load
//   CFG_W     16  bits per LUT config (2^inputs of lut4_1)
//   IDX_W     2   width of word index, = clog2(NUM_LUTS)
// PORTS
//   clk         in   1               clock; all state changes on rising edge
//   rst_n       in   1               reset, asynchronous, active-low
//   start       in   1               begin a load; sampled only in IDLE
//   cfg_valid   in   1               cfg_bit is valid this cycle
//   cfg_bit     in   1               serial config data, MSB of each word first, word 0 first
//   cfg_ready   out  1               loader accepts a bit this cycle
//   busy        out  1               high in any state except IDLE
//   done        out  1               one-cycle pulse: new configuration committed
//   cfg_err     out  1               sticky parity error flag (0 when parity compiled out)
//   lut_config  out  NUM_LUTS*CFG_W  committed configs; word i at [i*CFG_W +: CFG_W]
// BEHAVIOUR
//   - Reset (async, any state, mid-load included): state=IDLE, all shadow/output words=0,
//     bit count=0, index=0, cfg_ready=0, busy=0, done=0, cfg_err=0.
//   - States: IDLE, SHIFT, [PARITY], COMMIT, DONE.
//   - IDLE: cfg_ready=0. start=1 -> SHIFT, index=0, bit count=0, cfg_err cleared.
//   - SHIFT: cfg_ready=1. A bit is accepted on an edge with cfg_valid&&cfg_ready; shift reg <= {sr[CFG_W-2:0],cfg_bit}.
//     cfg_valid low stalls with no state change. On the CFG_W-th accepted bit -> COMMIT (or PARITY).
//   - COMMIT (1 cycle, cfg_ready=0): shadow[index] <= shift reg. If index==NUM_LUTS-1 -> DONE, else index++ -> SHIFT.
//   - DONE (1 cycle): lut_config <= all shadow words, done=1 -> IDLE. lut_config changes only at this edge.
//   - Latency: with cfg_valid held high, the edge sampling start is edge 0. done is high after edge 1+NUM_LUTS*(CFG_W+1).
//     Defaults: 69 (parity off), 73 (parity on).
//   - start while busy is ignored. cfg_valid in IDLE/COMMIT/DONE is ignored; no bit is consumed.
//   - Shift-register contents are not cleared between words; the bit counter alone bounds each word.
//   - Index wraps never: load ends at NUM_LUTS-1. The bit counter is CFG_W-wide-safe: clog2(CFG_W+1) bits.
// CONFIGURATION
//   LUT_CFG_PARITY_EN defined:
//   - After each word's CFG_W bits, state PARITY accepts one even-parity bit (cfg_ready=1).
//   - If ^{word,bit}==0 -> COMMIT.
//   - Otherwise: cfg_err=1, shadow words discarded, lut_config keeps its previous value, no done pulse, -> IDLE.
//   - cfg_err stays high until the next accepted start or reset.
//   LUT_CFG_PARITY_EN undefined: no PARITY state, cfg_err tied 0.
// STRUCTURE
//   - Package lut_cfg_pkg: CFG_W/NUM_LUTS defaults, state encoding localparams (IDLE=0,SHIFT=1,PARITY=2,COMMIT=3,DONE=4),
//     and a word-parity function.
//   - Sub-module cfg_shift_reg: serial-in shift register plus bit counter. Ports: clk, rst_n, clr, shift_en, bit_in,
//     word_out, count_full. The FSM, shadow array and output register stay in lut_cfg_loader.
// TESTING
//   - Reset: assert rst_n=0 mid-SHIFT after 7 bits -> next cycle lut_config=0, busy=0, cfg_ready=0, state IDLE.
//   - Full load, valid held high: words 16'h0001,16'h8000,16'hFFFF,16'hA5A5 -> done at edge 69,
//     lut_config=64'hA5A5_FFFF_8000_0001, and lut4_1 driven from word 0 outputs 1 for inputs 4'b0000.
//   - Stalls: cfg_valid toggled 1-0-1 each cycle during the same load -> identical final lut_config,
//     done at edge 1+4*(32)-? i.e. per bit +1 cycle per stall, and no bits are lost or duplicated.
//   - Atomicity: after a prior load, a second load -> lut_config holds old value through edge 68 and changes only with done.
//   - start pulses during SHIFT/COMMIT -> ignored; index and bit count unchanged; one done per load.
//   - [LUT_CFG_PARITY_EN] word 16'h0001 with parity bit 0 -> cfg_err=1, no done, lut_config unchanged, IDLE.
//     Parity bit 1 -> accepted.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the LUT configuration loader: default sizes, FSM state
// encoding and the word parity helper used when LUT_CFG_PARITY_EN is defined.
package lut_cfg_pkg;

  localparam int unsigned DEF_NUM_LUTS = 4;
  localparam int unsigned DEF_CFG_W    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Even-parity bit that makes ^{word, bit} == 0.
  function automatic logic word_parity(input logic [DEF_CFG_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial-in shift register (MSB first) with a per-word bit counter; count_full
// flags the accept that completes a CFG_W-bit word.
module cfg_shift_reg #(
  parameter int unsigned CFG_W = 16,
  parameter int unsigned CNT_W = $clog2(CFG_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [CFG_W-1:0] word_out,
  output logic             count_full
);

  logic [CFG_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (shift_en) begin
      sr_d  = {sr_q[CFG_W-2:0], bit_in};
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_out   = sr_q;
  assign count_full = shift_en && (cnt_q == CNT_W'(CFG_W - 1));

endmodule

// File: rtl/lut_cfg_loader.sv
// Serial LUT configuration loader: shadows NUM_LUTS words and commits them
// atomically to lut_config. Define LUT_CFG_PARITY_EN for a per-word even-parity bit.
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int unsigned NUM_LUTS = DEF_NUM_LUTS,
  parameter int unsigned CFG_W    = DEF_CFG_W,
  parameter int unsigned IDX_W    = $clog2(NUM_LUTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      cfg_valid,
  input  logic                      cfg_bit,
  output logic                      cfg_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err,
  output logic [NUM_LUTS*CFG_W-1:0] lut_config
);

  state_e                           state_q;
  logic [IDX_W-1:0]                 idx_q;
  logic [NUM_LUTS-1:0][CFG_W-1:0]   shadow_q;
  logic [NUM_LUTS-1:0][CFG_W-1:0]   cfg_q;
  logic                             ready_q, busy_q, done_q, err_q;

  logic             shift_en, clr, word_full;
  logic [CFG_W-1:0] word;

  assign shift_en = cfg_valid && ready_q && (state_q == SHIFT);
  assign clr      = ((state_q == IDLE) && start) || (state_q == COMMIT);

  cfg_shift_reg #(.CFG_W(CFG_W)) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .shift_en   (shift_en),
    .bit_in     (cfg_bit),
    .word_out   (word),
    .count_full (word_full)
  );

  // Outputs are registered alongside the state so they always match it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            idx_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (word_full) begin
`ifdef LUT_CFG_PARITY_EN
            state_q <= PARITY;
`else
            state_q <= COMMIT;
            ready_q <= 1'b0;
`endif
          end
        end
`ifdef LUT_CFG_PARITY_EN
        PARITY: begin
          if (cfg_valid) begin
            ready_q <= 1'b0;
            if (word_parity(word) == cfg_bit) begin
              state_q <= COMMIT;
            end else begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              err_q    <= 1'b1;
              shadow_q <= '0;
            end
          end
        end
`endif
        COMMIT: begin
          shadow_q[idx_q] <= word;
          if (idx_q == IDX_W'(NUM_LUTS - 1)) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= SHIFT;
            ready_q <= 1'b1;
          end
        end
        DONE: begin
          cfg_q   <= shadow_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready  = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = err_q;
  assign lut_config = cfg_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Self-checking bench for lut_cfg_loader: table-driven loads, randomized loads
// against a bit-queue model, reset and (with LUT_CFG_PARITY_EN) parity sequences.
module tb_lut_cfg_loader;

`ifdef LUT_CFG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LAT = 1 + 4 * (16 + 1 + PAR);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        cfg_ready, busy, done, cfg_err;
  logic [63:0] lut_config;

  int n_cmp = 0;
  int n_bad = 0;

  lut_cfg_loader #(.NUM_LUTS(4), .CFG_W(16), .IDX_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .cfg_ready  (cfg_ready),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err),
    .lut_config (lut_config)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends one load; the model is the flat bit list the spec describes.
  task automatic run_load(input logic [3:0][15:0] w, input int mode, input bit inj,
                          input logic [63:0] exp_cfg, input int exp_lat);
    bit          q[$];
    int          ptr, lat, viol;
    logic        rdy, v;
    logic [63:0] old;
    for (int i = 0; i < 4; i++) begin
      for (int b = 15; b >= 0; b--) q.push_back(w[i][b]);
      if (PAR != 0) q.push_back(^w[i]);
    end
    old = lut_config;
    ptr = 0; lat = -1; viol = 0;
    start = 1'b1; cfg_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    for (int e = 1; e <= 400 && lat < 0; e++) begin
      rdy = cfg_ready;
      case (mode)
        0:       v = 1'b1;
        1:       v = (e % 2 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      cfg_valid = v;
      cfg_bit   = (ptr < q.size()) ? q[ptr] : 1'($urandom_range(0, 1));
      start     = inj && ((e % 11 == 5) || (e % 17 == 0));
      @(posedge clk); #1;
      if (v && rdy) ptr++;
      if (done) lat = e;
      else if (lut_config !== old) viol++;
    end
    start = 1'b0; cfg_valid = 1'b0;
    chk("done_seen", {63'd0, lat >= 0}, 64'd1);
    if (exp_lat >= 0) chk("latency", 64'(lat), 64'(exp_lat));
    chk("lut_config", lut_config, exp_cfg);
    chk("bits_accepted", 64'(ptr), 64'(q.size()));
    chk("atomic_hold", 64'(viol), 64'd0);
    chk("err_clear", {63'd0, cfg_err}, 64'd0);
    @(posedge clk); #1;
    chk("done_pulse_1cyc", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_ready", {63'd0, cfg_ready}, 64'd0);
  endtask

  typedef struct {
    logic [3:0][15:0] w;
    int               mode;
    bit               inj;
    logic [63:0]      exp_cfg;
    int               exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [3:0][15:0] rw;
    logic [63:0]      old;
    int               dcnt;
    vecs[0] = '{{16'hA5A5, 16'hFFFF, 16'h8000, 16'h0001}, 0, 1'b0, 64'hA5A5_FFFF_8000_0001, LAT};
    vecs[1] = '{{16'hA5A5, 16'hFFFF, 16'h8000, 16'h0001}, 1, 1'b0, 64'hA5A5_FFFF_8000_0001, -1};
    vecs[2] = '{{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, 1'b0, 64'h0, LAT};
    vecs[3] = '{{16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, 2, 1'b0, 64'hDEF0_9ABC_5678_1234, -1};
    vecs[4] = '{{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000}, 0, 1'b1, 64'hFFFF_0000_FFFF_0000, LAT};

    #12;
    chk("reset_cfg", lut_config, 64'h0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_ready", {63'd0, cfg_ready}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_err", {63'd0, cfg_err}, 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i].w, vecs[i].mode, vecs[i].inj, vecs[i].exp_cfg, vecs[i].exp_lat);
      if (i == 0) begin
        rw = lut_config;
        chk("lut4_1_in0000", {63'd0, rw[0][4'b0000]}, 64'd1);
      end
    end

    for (int i = 0; i < 8; i++) begin
      int m;
      for (int k = 0; k < 4; k++) rw[k] = 16'($urandom);
      m = $urandom_range(0, 2);
      run_load(rw, m, 1'($urandom_range(0, 1)), rw, (m == 0) ? LAT : -1);
    end

    // Asynchronous reset part-way through the first word.
    start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0; #1;
    chk("arst_cfg", lut_config, 64'h0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_ready", {63'd0, cfg_ready}, 64'd0);
    @(posedge clk); #1;
    chk("arst_cfg_next", lut_config, 64'h0);
    chk("arst_ready_next", {63'd0, cfg_ready}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ignores_valid", {62'd0, cfg_ready, busy}, 64'd0);
    cfg_valid = 1'b0;
    run_load({16'h0F0F, 16'h3C3C, 16'h1111, 16'h8001}, 0, 1'b0, 64'h0F0F_3C3C_1111_8001, LAT);

`ifdef LUT_CFG_PARITY_EN
    // Word 0 = 0001 with a wrong parity bit must abort the load.
    begin
      logic [15:0] pw;
      pw = 16'h0001;
      old = lut_config;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int b = 15; b >= 0; b--) begin
        cfg_valid = 1'b1; cfg_bit = pw[b];
        @(posedge clk); #1;
      end
      cfg_bit = 1'b0;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      chk("par_err", {63'd0, cfg_err}, 64'd1);
      chk("par_idle", {62'd0, busy, cfg_ready}, 64'd0);
      dcnt = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (done) dcnt++;
      end
      chk("par_no_done", 64'(dcnt), 64'd0);
      chk("par_cfg_kept", lut_config, old);
      chk("par_err_sticky", {63'd0, cfg_err}, 64'd1);
      run_load({16'h0003, 16'h0002, 16'h0000, 16'h0001}, 0, 1'b0, 64'h0003_0002_0000_0001, LAT);
    end
`else
    old = lut_config;
    dcnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("no_spurious_done", 64'(dcnt), 64'd0);
    chk("cfg_stable_idle", lut_config, old);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
